gpr_file: RTL
=============

# gpr_file

Parametrised multi-port general-purpose register file for the next-generation core. It provides two combinational read ports and two synchronous write ports, with optional same-cycle write-to-read bypass and a per-register pending-write scoreboard. A post-reset init sequencer zeroes every register and raises `init_done` only when the array is clean. It replaces the single-write-port register file and sits between decode (reads, scoreboard set) and writeback (ALU port A, load port B).

## Interface
Parameters:
- `XLEN`, 32: register width in bits.
- `NREGS`, 32: number of registers. Power of two, ≥ 2. Register 0 is hard-wired zero.
- `ADDR_W`, 5: address width. Must equal log2(NREGS).
- `BYPASS`, 1: 1 = a read of a register being written this cycle returns the write data; 0 = it returns the stored value.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `init_done`  out  1  high once the zeroing sequence has completed.
- `rs1_addr`, `rs2_addr`  in  ADDR_W  read addresses.
- `rs1_data`, `rs2_data`  out  XLEN  read data (combinational).
- `rs1_busy`, `rs2_busy`  out  1  scoreboard bit of the addressed register (combinational).
- `wa_en`, `wb_en`  in  1  write enables, port A (ALU) and port B (load).
- `wa_addr`, `wb_addr`  in  ADDR_W  write addresses.
- `wa_data`, `wb_data`  in  XLEN  write data.
- `sb_set_en`  in  1  mark a register as having a write pending.
- `sb_set_addr`  in  ADDR_W  register to mark.

## Operation
- Two-state FSM, INIT and RUN, plus a counter `cnt` of ADDR_W bits.
- Reset asserted, asynchronously: state = INIT, `cnt` = 0, `init_done` = 0, all busy bits = 0. Array contents are undefined until INIT completes.
- INIT, each edge: reg[`cnt`] ← 0, then `cnt` increments.
  - The edge that writes reg[NREGS−1] also moves the FSM to RUN and sets `init_done` = 1.
  - During INIT, `wa_en`, `wb_en` and `sb_set_en` are ignored.
  - During INIT, `rs*_data` = 0 and `rs*_busy` = 0.
- RUN, writes:
  - reg[addr] ← data for each enabled port whose addr ≠ 0. A write to address 0 is discarded.
  - Both ports enabled with the same address: port B wins.
- Reads:
  - Address 0 always returns 0 with busy = 0.
  - When BYPASS = 1 and an enabled write port matches the read address (≠ 0), that port's data is returned; port B has priority over port A. Otherwise the stored value is returned.
  - `rs*_busy` always reflects the registered busy bit. There is no bypass on busy.
- Scoreboard in RUN:
  - busy[r] is cleared at the edge where either write port writes r.
  - busy[r] is set at the edge where `sb_set_en` is high and `sb_set_addr` = r ≠ 0.
  - Set and clear of the same r on the same edge: set wins, because a new producer has been issued.
  - Setting an already-busy register leaves it busy.
  - `sb_set_addr` = 0 has no effect.
- Reset asserted mid-RUN or mid-INIT: immediate return to INIT with `cnt` = 0, all busy bits cleared and `init_done` low. Writes on the edge coincident with reset assertion are lost.

## Timing
- Read latency is 0 cycles: combinational from address, and from write inputs when BYPASS = 1.
- With BYPASS = 0, a written value is visible at the read port the cycle after the write edge.
- Busy is visible the cycle after the set edge. A busy clear is visible the cycle after the write edge.
- INIT lasts exactly NREGS rising edges after `reset_n` deasserts. `init_done` rises after edge NREGS.
- Write inputs present on edge NREGS are ignored. The first accepted write is on edge NREGS+1.
- `init_done` stays high until the next reset and has no other dependencies.

## Test plan
- Init: preload the array with nonzero values and pulse `reset_n` low. Require `init_done` = 0 for 32 edges and 1 after edge 32. Then every rs1 read of 0..31 returns 0 and every busy = 0.
- Basic write/read: wa write 0xDEADBEEF to r5, wb write 0x12345678 to r9. The next cycle, rs1 = r5 → 0xDEADBEEF and rs2 = r9 → 0x12345678. A write of 0xFFFFFFFF to r0 → rs1 = r0 reads 0.
- Port conflict and bypass (BYPASS = 1): wa(r7, 0xAAAA0000) and wb(r7, 0x0000BBBB) on the same edge with rs1 = r7. Same-cycle rs1 = 0x0000BBBB, and the stored value afterwards is 0x0000BBBB. Repeat with BYPASS = 0: same-cycle rs1 shows the old value, and 0x0000BBBB appears next cycle.
- Scoreboard: set r3, then rs1_busy = 1 the next cycle. A wa write to r3 → busy = 0 the cycle after. Set r3 and write r3 on the same edge → busy stays 1. Set r0 → busy stays 0.
- Reset mid-operation: with r4 = 0x55 and r4 busy, drop `reset_n` asynchronously between edges. `init_done` and `rs*_busy` go to 0 immediately. After re-init, r4 reads 0.
- Parameter sweep: XLEN = 64, NREGS = 16, ADDR_W = 4. Init takes 16 edges, and a 64-bit write/read of r15 = 0x0123456789ABCDEF round-trips.

Source files
------------

// File: rtl/gpr_file_if.sv
// Register-file port bundle: two read ports, two write ports and scoreboard set.
// The core side drives through master; the register file sits on slave.
interface gpr_file_if #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 5
);
    logic              init_done;
    logic [ADDR_W-1:0] rs1_addr;
    logic [ADDR_W-1:0] rs2_addr;
    logic [XLEN-1:0]   rs1_data;
    logic [XLEN-1:0]   rs2_data;
    logic              rs1_busy;
    logic              rs2_busy;
    logic              wa_en;
    logic [ADDR_W-1:0] wa_addr;
    logic [XLEN-1:0]   wa_data;
    logic              wb_en;
    logic [ADDR_W-1:0] wb_addr;
    logic [XLEN-1:0]   wb_data;
    logic              sb_set_en;
    logic [ADDR_W-1:0] sb_set_addr;

    modport master (
        input  init_done, rs1_data, rs2_data, rs1_busy, rs2_busy,
        output rs1_addr, rs2_addr, wa_en, wa_addr, wa_data,
               wb_en, wb_addr, wb_data, sb_set_en, sb_set_addr
    );

    modport slave (
        output init_done, rs1_data, rs2_data, rs1_busy, rs2_busy,
        input  rs1_addr, rs2_addr, wa_en, wa_addr, wa_data,
               wb_en, wb_addr, wb_data, sb_set_en, sb_set_addr
    );
endinterface

// File: rtl/gpr_file.sv
// Multi-port register file: 2 combinational reads, 2 writes (port B wins), optional
// write-to-read bypass, pending-write scoreboard and a post-reset zeroing sequencer.
module gpr_file #(
    parameter int XLEN   = 32,
    parameter int NREGS  = 32,
    parameter int ADDR_W = 5,
    parameter int BYPASS = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    gpr_file_if.slave   bus
);
    typedef enum logic {INIT, RUN} state_t;

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] cnt_reg, cnt_next;
    logic              init_done_reg, init_done_next;
    logic [XLEN-1:0]   regs_mem [NREGS];
    logic [NREGS-1:0]  busy_reg, busy_next;
    logic              run;
    logic              wa_we, wb_we;

    assign run   = (state_reg == RUN);
    assign wa_we = run && bus.wa_en && (bus.wa_addr != '0);
    assign wb_we = run && bus.wb_en && (bus.wb_addr != '0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg     <= INIT;
            cnt_reg       <= '0;
            init_done_reg <= 1'b0;
            busy_reg      <= '0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            init_done_reg <= init_done_next;
            busy_reg      <= busy_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        init_done_next = init_done_reg;
        if (state_reg == INIT) begin
            cnt_next = cnt_reg + 1'b1;
            if (cnt_reg == ADDR_W'(NREGS - 1)) begin
                state_next     = RUN;
                init_done_next = 1'b1;
            end
        end
    end

    // Port B is assigned last so it wins a same-address collision.
    always_ff @(posedge clk) begin
        if (!run) begin
            regs_mem[cnt_reg] <= '0;
        end else begin
            if (wa_we) regs_mem[bus.wa_addr] <= bus.wa_data;
            if (wb_we) regs_mem[bus.wb_addr] <= bus.wb_data;
        end
    end

    assign busy_next[0] = 1'b0;

    genvar gi;
    generate
        // A new set beats a completing write: a fresh producer has been issued.
        for (gi = 1; gi < NREGS; gi++) begin : g_busy
            logic set_hit, clr_hit;
            assign set_hit = run && bus.sb_set_en && (bus.sb_set_addr == ADDR_W'(gi));
            assign clr_hit = (wa_we && (bus.wa_addr == ADDR_W'(gi))) ||
                             (wb_we && (bus.wb_addr == ADDR_W'(gi)));
            assign busy_next[gi] = set_hit ? 1'b1 : (clr_hit ? 1'b0 : busy_reg[gi]);
        end

        for (gi = 0; gi < 2; gi++) begin : g_rd
            logic [ADDR_W-1:0] addr;
            logic [XLEN-1:0]   data;
            logic              busy;
            assign addr = (gi == 0) ? bus.rs1_addr : bus.rs2_addr;
            always_comb begin
                data = '0;
                busy = 1'b0;
                if (run && (addr != '0)) begin
                    busy = busy_reg[addr];
                    if ((BYPASS != 0) && wb_we && (bus.wb_addr == addr))
                        data = bus.wb_data;
                    else if ((BYPASS != 0) && wa_we && (bus.wa_addr == addr))
                        data = bus.wa_data;
                    else
                        data = regs_mem[addr];
                end
            end
        end
    endgenerate

    assign bus.rs1_data  = g_rd[0].data;
    assign bus.rs2_data  = g_rd[1].data;
    assign bus.rs1_busy  = g_rd[0].busy;
    assign bus.rs2_busy  = g_rd[1].busy;
    assign bus.init_done = init_done_reg;
endmodule
